// File: rtl/unified_mem_responder.sv
// Memory-side responder for the unified single-ported RAM: arbitrates fetch and
// load/store requests, applies wait states, and handles byte/half/word lanes.
module unified_mem_responder #(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] DATA_OFFSET = 32'd44,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [2:0]  d_func,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        busy
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_ACCESS2,
    S_RESP
  } state_t;

  state_t          state;
  logic [3:0]      wait_cnt;

  logic            req_is_data;
  logic            req_we;
  logic [2:0]      req_func;
  logic [1:0]      req_lane;
  logic [31:0]     req_wdata;
  logic [AW-1:0]   req_idx;
  logic            req_split;
  logic [15:0]     fetch_lo;

  logic [31:0]     ea;
  logic [AW-1:0]   next_idx;
  logic            cur_err;
  logic [3:0]      wr_be;
  logic [31:0]     wr_data;
  logic            unused_bits;

  logic [31:0]     mem [MEM_WORDS];

  // Reserved encodings, misalignment, and stores with unsigned/unknown widths all fault.
  function automatic logic access_err(input logic we, input logic [2:0] func,
                                      input logic [1:0] lane);
    case (func)
      3'b000:  return 1'b0;
      3'b001:  return lane[0];
      3'b010:  return (lane != 2'b00);
      3'b100:  return we;
      3'b101:  return we | lane[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  func,
                                              input logic [1:0]  lane);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = word >> {lane, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (func)
      3'b000:  return 32'(b);
      3'b001:  return 32'(h);
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] func, input logic [1:0] lane);
    case (func)
      3'b000:  return 4'b0001 << lane;
      3'b001:  return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] func, input logic [31:0] wd);
    case (func)
      3'b000:  return {4{wd[7:0]}};
      3'b001:  return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  assign ea          = d_addr + DATA_OFFSET;
  assign next_idx    = req_idx + AW'(1);
  assign cur_err     = access_err(req_we, req_func, req_lane);
  assign wr_be       = store_be(req_func, req_lane);
  assign wr_data     = store_lanes(req_func, req_wdata);
  assign unused_bits = ^{ea[31:AW+2], if_addr[31:AW+2], if_addr[0]};

  // Grants only in IDLE; data wins a tie.
  assign d_gnt  = rst & (state == S_IDLE) & d_req;
  assign if_gnt = rst & (state == S_IDLE) & if_req & ~d_req;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (d_gnt) begin
      req_is_data <= 1'b1;
      req_we      <= d_we;
      req_func    <= d_func;
      req_lane    <= ea[1:0];
      req_wdata   <= d_wdata;
      req_idx     <= ea[AW+1:2];
      req_split   <= 1'b0;
    end else if (if_gnt) begin
      req_is_data <= 1'b0;
      req_we      <= 1'b0;
      req_idx     <= if_addr[AW+1:2];
      req_split   <= if_addr[1];
    end
    if (state == S_ACCESS)
      fetch_lo <= mem[req_idx][31:16];
  end

  // Stores commit only in ACCESS, so a reset before then never touches RAM.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && req_is_data && req_we && !cur_err) begin
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) mem[req_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (d_gnt || if_gnt) begin
            wait_cnt <= '0;
            state    <= (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'(WAIT_STATES - 1)) begin
            wait_cnt <= '0;
            state    <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_ACCESS: begin
          if (req_is_data) begin
            d_rvalid <= 1'b1;
            d_err    <= cur_err;
            d_rdata  <= (cur_err || req_we) ? 32'h0
                        : load_extend(mem[req_idx], req_func, req_lane);
            state    <= S_RESP;
          end else if (req_split) begin
            state <= S_ACCESS2;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem[req_idx];
            state     <= S_RESP;
          end
        end
        S_ACCESS2: begin
          if_rvalid <= 1'b1;
          if_rdata  <= {mem[next_idx][15:0], fetch_lo};
          state     <= S_RESP;
        end
        S_RESP: begin
          if_rvalid <= 1'b0;
          d_rvalid  <= 1'b0;
          d_err     <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench for unified_mem_responder: scoreboard of expected responses,
// plus two extra instances for wait-state timing.
module tb_unified_mem_responder;

   localparam int WS    = 1;
   localparam int WS_A  = 0;
   localparam int WS_B  = 3;
   localparam int LIMIT = 40;
   localparam int NCYC  = 18;

   logic        clk, rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr;
   logic [2:0]  d_func;
   logic [31:0] d_wdata;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err, busy;

   logic        t_req;
   logic [31:0] t_addr;
   logic        a_if_gnt, a_if_rvalid, b_if_gnt, b_if_rvalid;
   logic [31:0] a_unused_if_rdata, a_unused_d_rdata, b_unused_if_rdata, b_unused_d_rdata;
   logic        a_unused_d_gnt, a_unused_d_rvalid, a_unused_d_err, a_unused_busy;
   logic        b_unused_d_gnt, b_unused_d_rvalid, b_unused_d_err, b_unused_busy;

   int          total, bad;
   logic [32:0] exp_d_q[$];
   logic [31:0] exp_if_q[$];

   unified_mem_responder #(.WAIT_STATES(WS)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_func(d_func), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err), .busy(busy)
   );

   unified_mem_responder #(.WAIT_STATES(WS_A)) dut_a (
      .clk(clk), .rst(rst),
      .if_req(t_req), .if_addr(t_addr), .if_gnt(a_if_gnt), .if_rvalid(a_if_rvalid),
      .if_rdata(a_unused_if_rdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_func(3'b000), .d_wdata(32'h0),
      .d_gnt(a_unused_d_gnt), .d_rvalid(a_unused_d_rvalid), .d_rdata(a_unused_d_rdata),
      .d_err(a_unused_d_err), .busy(a_unused_busy)
   );

   unified_mem_responder #(.WAIT_STATES(WS_B)) dut_b (
      .clk(clk), .rst(rst),
      .if_req(t_req), .if_addr(t_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
      .if_rdata(b_unused_if_rdata),
      .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_func(3'b000), .d_wdata(32'h0),
      .d_gnt(b_unused_d_gnt), .d_rvalid(b_unused_d_rvalid), .d_rdata(b_unused_d_rdata),
      .d_err(b_unused_d_err), .busy(b_unused_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the response pulse.
   task automatic data_txn(input logic we, input logic [2:0] func, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input string tag);
      int          cyc;
      logic [32:0] e;
      exp_d_q.push_back({exp_err, exp_rd});
      d_req = 1'b1; d_we = we; d_func = func; d_addr = addr; d_wdata = wd;
      #1;
      cyc = 0;
      while (!d_gnt && cyc < LIMIT) begin @(negedge clk); #1; cyc++; end
      check({tag, "_gnt"}, d_gnt, 1);
      @(posedge clk); #1;
      d_req = 1'b0;
      cyc = 0;
      while (!d_rvalid && cyc < LIMIT) begin @(negedge clk); cyc++; end
      check({tag, "_lat"}, cyc, WS + 2);
      check({tag, "_rvalid"}, d_rvalid, 1);
      e = exp_d_q.pop_front();
      check({tag, "_rdata"}, d_rdata, e[31:0]);
      check({tag, "_err"}, d_err, e[32]);
      @(negedge clk);
      check({tag, "_pulse"}, d_rvalid, 0);
   endtask

   task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] exp_rd,
                            input string tag, output int gwait, output int lat);
      logic [31:0] e;
      exp_if_q.push_back(exp_rd);
      if_req = 1'b1; if_addr = addr;
      #1;
      gwait = 0;
      while (!if_gnt && gwait < LIMIT) begin @(negedge clk); #1; gwait++; end
      check({tag, "_gnt"}, if_gnt, 1);
      @(posedge clk); #1;
      if_req = 1'b0;
      lat = 0;
      while (!if_rvalid && lat < LIMIT) begin @(negedge clk); lat++; end
      check({tag, "_lat"}, lat, WS + 2 + int'(addr[1]));
      check({tag, "_rvalid"}, if_rvalid, 1);
      e = exp_if_q.pop_front();
      check({tag, "_rdata"}, if_rdata, e);
      @(negedge clk);
      check({tag, "_pulse"}, if_rvalid, 0);
   endtask

   initial begin
      int          gw, lat_al, lat_sp, cyc, gcyc;
      logic        d_seen;
      logic [32:0] e;
      logic [31:0] e_if;
      logic [NCYC-1:0] g_a, v_a, g_b, v_b, xg_a, xv_a, xg_b, xv_b;

      total = 0; bad = 0;
      rst = 1'b0; if_req = 1'b0; if_addr = '0; t_req = 1'b0; t_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_func = 3'b000; d_wdata = '0;

      // Reset state, with requests held to show the grants are gated
      repeat (3) @(negedge clk);
      d_req = 1'b1; if_req = 1'b1;
      #1;
      check("rst_d_gnt", d_gnt, 0);
      check("rst_if_gnt", if_gnt, 0);
      check("rst_busy", busy, 0);
      check("rst_d_rvalid", d_rvalid, 0);
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_d_rdata", d_rdata, 0);
      check("rst_if_rdata", if_rdata, 0);
      check("rst_d_err", d_err, 0);
      d_req = 1'b0; if_req = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Stores and lane-extended loads
      data_txn(1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, "sw0");
      data_txn(1'b0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, "lw0");
      data_txn(1'b0, 3'b000, 32'h3, 32'h0, 32'hFFFFFFDE, 1'b0, "lb3");
      data_txn(1'b0, 3'b100, 32'h3, 32'h0, 32'h000000DE, 1'b0, "lbu3");
      data_txn(1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFFDEAD, 1'b0, "lh2");
      data_txn(1'b0, 3'b101, 32'h2, 32'h0, 32'h0000DEAD, 1'b0, "lhu2");
      data_txn(1'b0, 3'b000, 32'h0, 32'h0, 32'hFFFFFFEF, 1'b0, "lb0");
      data_txn(1'b0, 3'b001, 32'h0, 32'h0, 32'hFFFFBEEF, 1'b0, "lh0");
      data_txn(1'b1, 3'b000, 32'h1, 32'hFFFFFF5A, 32'h0, 1'b0, "sb1");
      data_txn(1'b0, 3'b010, 32'h0, 32'h0, 32'hDEAD5AEF, 1'b0, "lw_sb");
      data_txn(1'b1, 3'b001, 32'h2, 32'hABCD1234, 32'h0, 1'b0, "sh2");
      data_txn(1'b0, 3'b010, 32'h0, 32'h0, 32'h12345AEF, 1'b0, "lw_sh");
      data_txn(1'b1, 3'b010, 32'h0, 32'hDEADBEEF, 32'h0, 1'b0, "sw_restore");

      // Error responses leave RAM alone
      data_txn(1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, "lw_mis");
      data_txn(1'b1, 3'b001, 32'h1, 32'h5555, 32'h0, 1'b1, "sh_mis");
      data_txn(1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, "func011");
      data_txn(1'b1, 3'b100, 32'h0, 32'h77, 32'h0, 1'b1, "sbu_store");
      data_txn(1'b0, 3'b010, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, "lw_after_err");

      // Reset during the WAIT of a store
      d_req = 1'b1; d_we = 1'b1; d_func = 3'b010; d_addr = 32'h0; d_wdata = 32'h12345678;
      #1;
      check("rw_gnt", d_gnt, 1);
      @(posedge clk); #1;
      d_req = 1'b0;
      @(negedge clk);
      check("rw_busy_wait", busy, 1);
      rst = 1'b0; if_req = 1'b1; if_addr = 32'h2C;
      #1;
      check("rw_busy", busy, 0);
      check("rw_d_rvalid", d_rvalid, 0);
      check("rw_d_rdata", d_rdata, 0);
      check("rw_d_err", d_err, 0);
      check("rw_if_gnt", if_gnt, 0);
      @(negedge clk);
      check("rw_busy_hold", busy, 0);
      rst = 1'b1;
      fetch_txn(32'h2C, 32'hDEADBEEF, "rw_fetch", gw, lat_al);
      check("rw_regrant", gw, 0);

      // Aligned and split fetches
      data_txn(1'b1, 3'b010, 32'hFFFFFFD8, 32'h11112222, 32'h0, 1'b0, "sw_w1");
      data_txn(1'b1, 3'b010, 32'hFFFFFFDC, 32'h33334444, 32'h0, 1'b0, "sw_w2");
      fetch_txn(32'h4, 32'h11112222, "f_al", gw, lat_al);
      fetch_txn(32'h6, 32'h44441111, "f_split", gw, lat_sp);
      check("split_extra_cycle", lat_sp, lat_al + 1);

      // Split fetch at the last word wraps to word 0
      data_txn(1'b1, 3'b010, 32'h00000FD0, 32'hAAAABBBB, 32'h0, 1'b0, "sw_top");
      data_txn(1'b1, 3'b010, 32'hFFFFFFD4, 32'hCCCCDDDD, 32'h0, 1'b0, "sw_bot");
      fetch_txn(32'h00000FFE, 32'hDDDDAAAA, "f_wrap", gw, lat_sp);

      // Simultaneous requests: data first, fetch on the next IDLE
      exp_d_q.push_back({1'b0, 32'hDEADBEEF});
      exp_if_q.push_back(32'h11112222);
      d_req = 1'b1; d_we = 1'b0; d_func = 3'b010; d_addr = 32'h0;
      if_req = 1'b1; if_addr = 32'h4;
      #1;
      check("tie_d_gnt", d_gnt, 1);
      check("tie_if_gnt", if_gnt, 0);
      @(posedge clk); #1;
      d_req = 1'b0;
      cyc = 0; gcyc = -1; d_seen = 1'b0;
      while (gcyc < 0 && cyc < LIMIT) begin
         @(negedge clk); cyc++;
         if (d_rvalid) begin
            d_seen = 1'b1;
            e = exp_d_q.pop_front();
            check("tie_d_rdata", d_rdata, e[31:0]);
         end
         if (if_gnt) gcyc = cyc;
      end
      check("tie_d_seen", d_seen, 1);
      check("tie_if_gnt_cycle", gcyc, WS + 3);
      @(posedge clk); #1;
      if_req = 1'b0;
      cyc = 0;
      while (!if_rvalid && cyc < LIMIT) begin @(negedge clk); cyc++; end
      check("tie_f_lat", cyc, WS + 2);
      e_if = exp_if_q.pop_front();
      check("tie_f_rdata", if_rdata, e_if);
      @(negedge clk);

      // Back-to-back aligned fetches at two other wait-state settings
      t_req = 1'b1; t_addr = 32'h0;
      for (int c = 0; c < NCYC; c++) begin
         #1;
         g_a[c] = a_if_gnt; v_a[c] = a_if_rvalid;
         g_b[c] = b_if_gnt; v_b[c] = b_if_rvalid;
         xg_a[c] = (c % (WS_A + 3) == 0);
         xv_a[c] = (c % (WS_A + 3) == WS_A + 2);
         xg_b[c] = (c % (WS_B + 3) == 0);
         xv_b[c] = (c % (WS_B + 3) == WS_B + 2);
         @(negedge clk);
      end
      t_req = 1'b0;
      check("ws0_gnt_pattern", 32'(g_a), 32'(xg_a));
      check("ws0_rvalid_pattern", 32'(v_a), 32'(xv_a));
      check("ws3_gnt_pattern", 32'(g_b), 32'(xg_b));
      check("ws3_rvalid_pattern", 32'(v_b), 32'(xv_b));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
